// File: rtl/id_decode_ctrl.sv
// IF/ID pipeline register with combinational field extraction and control decode.
// Fields and controls come from the registered instruction, so they are valid right after the loading edge.
module id_decode_ctrl #(
    parameter int unsigned PC_W = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            IF_ID_flush,
    input  logic [31:0]     instruction,
    input  logic [PC_W-1:0] currPC,
    output logic [PC_W-1:0] currPC_out,
    output logic [10:0]     opcode,
    output logic [4:0]      Rn,
    output logic [4:0]      Rm,
    output logic [4:0]      Rd,
    output logic [5:0]      shamt,
    output logic [8:0]      dAddr9,
    output logic [11:0]     ALU_Imm,
    output logic [18:0]     condAddr19,
    output logic [25:0]     brAddr26,
    output logic            uncondBr,
    output logic            branch,
    output logic            Reg2Loc,
    output logic            ALU_Src,
    output logic            RegWrite,
    output logic            ALU_SH,
    output logic            Imm,
    output logic            memToReg,
    output logic            memWrite,
    output logic            memRead,
    output logic            shiftDirn,
    output logic            ALU_on,
    output logic            set_flags,
    output logic            branchReg,
    output logic            branchLink,
    output logic [2:0]      ALU_cntrl
);

    localparam int unsigned INSTR_W = 32;

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_SUB    = 3'b011;

    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc;

    // IF/ID register: a flush loads an all-zero bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr <= '0;
            r_pc    <= '0;
        end else if (IF_ID_flush) begin
            r_instr <= '0;
            r_pc    <= '0;
        end else begin
            r_instr <= instruction;
            r_pc    <= currPC;
        end
    end

    assign currPC_out = r_pc;
    assign opcode     = r_instr[31:21];
    assign Rn         = r_instr[9:5];
    assign Rm         = r_instr[20:16];
    assign Rd         = r_instr[4:0];
    assign shamt      = r_instr[15:10];
    assign dAddr9     = r_instr[20:12];
    assign ALU_Imm    = r_instr[21:10];
    assign condAddr19 = r_instr[23:5];
    assign brAddr26   = r_instr[25:0];

    logic       w_uncond_br;
    logic       w_branch;
    logic       w_reg2loc;
    logic       w_alu_src;
    logic       w_reg_write;
    logic       w_alu_sh;
    logic       w_imm;
    logic       w_mem_to_reg;
    logic       w_mem_write;
    logic       w_mem_read;
    logic       w_shift_dirn;
    logic       w_alu_on;
    logic       w_set_flags;
    logic       w_branch_reg;
    logic       w_branch_link;
    logic [2:0] w_alu_cntrl;
    logic [2:0] w_mem_cntrl;

    // Loads/stores with a negative 9-bit offset subtract from the base
    assign w_mem_cntrl = dAddr9[8] ? ALU_SUB : ALU_ADD;

    always_comb begin
        w_uncond_br   = 1'b0;
        w_branch      = 1'b0;
        w_reg2loc     = 1'b0;
        w_alu_src     = 1'b0;
        w_reg_write   = 1'b0;
        w_alu_sh      = 1'b0;
        w_imm         = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_mem_write   = 1'b0;
        w_mem_read    = 1'b0;
        w_shift_dirn  = 1'b0;
        w_alu_on      = 1'b0;
        w_set_flags   = 1'b0;
        w_branch_reg  = 1'b0;
        w_branch_link = 1'b0;
        w_alu_cntrl   = ALU_PASS_B;
        casez (opcode)
            11'b1001000100?: begin // ADDI
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
                w_imm       = 1'b1;
                w_alu_on    = 1'b1;
                w_alu_cntrl = ALU_ADD;
            end
            11'b10101011000: begin // ADDS
                w_reg_write = 1'b1;
                w_reg2loc   = 1'b1;
                w_alu_on    = 1'b1;
                w_set_flags = 1'b1;
                w_alu_cntrl = ALU_ADD;
            end
            11'b11101011000: begin // SUBS
                w_reg_write = 1'b1;
                w_reg2loc   = 1'b1;
                w_alu_on    = 1'b1;
                w_set_flags = 1'b1;
                w_alu_cntrl = ALU_SUB;
            end
            11'b11010011011: begin // LSL
                w_reg_write = 1'b1;
                w_alu_sh    = 1'b1;
            end
            11'b11010011010: begin // LSR
                w_reg_write  = 1'b1;
                w_alu_sh     = 1'b1;
                w_shift_dirn = 1'b1;
            end
            11'b11111000010: begin // LDUR
                w_reg_write  = 1'b1;
                w_alu_src    = 1'b1;
                w_alu_on     = 1'b1;
                w_mem_to_reg = 1'b1;
                w_mem_read   = 1'b1;
                w_alu_cntrl  = w_mem_cntrl;
            end
            11'b11111000000: begin // STUR
                w_alu_src   = 1'b1;
                w_alu_on    = 1'b1;
                w_mem_write = 1'b1;
                w_alu_cntrl = w_mem_cntrl;
            end
            11'b000101?????: begin // B
                w_branch    = 1'b1;
                w_uncond_br = 1'b1;
            end
            11'b100101?????: begin // BL
                w_branch      = 1'b1;
                w_uncond_br   = 1'b1;
                w_branch_link = 1'b1;
                w_reg_write   = 1'b1;
            end
            11'b10110100???: begin // CBZ
                w_branch    = 1'b1;
                w_alu_on    = 1'b1;
                w_alu_cntrl = ALU_PASS_B;
            end
            11'b01010100???: begin // B.cond
                w_branch = 1'b1;
            end
            11'b11010110000: begin // BR
                w_branch     = 1'b1;
                w_branch_reg = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Reset forces every control low independent of the register contents
    assign uncondBr   = rst & w_uncond_br;
    assign branch     = rst & w_branch;
    assign Reg2Loc    = rst & w_reg2loc;
    assign ALU_Src    = rst & w_alu_src;
    assign RegWrite   = rst & w_reg_write;
    assign ALU_SH     = rst & w_alu_sh;
    assign Imm        = rst & w_imm;
    assign memToReg   = rst & w_mem_to_reg;
    assign memWrite   = rst & w_mem_write;
    assign memRead    = rst & w_mem_read;
    assign shiftDirn  = rst & w_shift_dirn;
    assign ALU_on     = rst & w_alu_on;
    assign set_flags  = rst & w_set_flags;
    assign branchReg  = rst & w_branch_reg;
    assign branchLink = rst & w_branch_link;
    assign ALU_cntrl  = (rst && w_alu_on) ? w_alu_cntrl : ALU_PASS_B;

endmodule

// File: tb/tb_id_decode_ctrl.sv
// Directed self-checking bench for id_decode_ctrl: reset, decode, flush and async reset.
module tb_id_decode_ctrl;

    localparam int unsigned PC_W = 64;

    logic            clk;
    logic            rst;
    logic            IF_ID_flush;
    logic [31:0]     instruction;
    logic [PC_W-1:0] currPC;
    logic [PC_W-1:0] currPC_out;
    logic [10:0]     opcode;
    logic [4:0]      Rn, Rm, Rd;
    logic [5:0]      shamt;
    logic [8:0]      dAddr9;
    logic [11:0]     ALU_Imm;
    logic [18:0]     condAddr19;
    logic [25:0]     brAddr26;
    logic uncondBr, branch, Reg2Loc, ALU_Src, RegWrite, ALU_SH, Imm, memToReg;
    logic memWrite, memRead, shiftDirn, ALU_on, set_flags, branchReg, branchLink;
    logic [2:0]      ALU_cntrl;

    int checks = 0;
    int errors = 0;

    id_decode_ctrl #(.PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .IF_ID_flush(IF_ID_flush),
        .instruction(instruction), .currPC(currPC), .currPC_out(currPC_out),
        .opcode(opcode), .Rn(Rn), .Rm(Rm), .Rd(Rd), .shamt(shamt),
        .dAddr9(dAddr9), .ALU_Imm(ALU_Imm), .condAddr19(condAddr19), .brAddr26(brAddr26),
        .uncondBr(uncondBr), .branch(branch), .Reg2Loc(Reg2Loc), .ALU_Src(ALU_Src),
        .RegWrite(RegWrite), .ALU_SH(ALU_SH), .Imm(Imm), .memToReg(memToReg),
        .memWrite(memWrite), .memRead(memRead), .shiftDirn(shiftDirn), .ALU_on(ALU_on),
        .set_flags(set_flags), .branchReg(branchReg), .branchLink(branchLink),
        .ALU_cntrl(ALU_cntrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Order: uncondBr branch Reg2Loc ALU_Src RegWrite ALU_SH Imm memToReg memWrite memRead shiftDirn ALU_on set_flags branchReg branchLink
    logic [14:0] w_ctrl;
    assign w_ctrl = {uncondBr, branch, Reg2Loc, ALU_Src, RegWrite, ALU_SH, Imm, memToReg,
                     memWrite, memRead, shiftDirn, ALU_on, set_flags, branchReg, branchLink};

    task automatic load(input logic [31:0] ins, input logic [PC_W-1:0] pc, input logic fl);
        @(negedge clk);
        instruction = ins;
        currPC      = pc;
        IF_ID_flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; IF_ID_flush = 1'b1; instruction = 32'h91000C22; currPC = 64'h1234;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (w_ctrl !== 15'd0 || ALU_cntrl !== 3'd0) begin
            errors++; $display("FAIL reset_ctrl got %b/%b exp 0/0", w_ctrl, ALU_cntrl);
        end
        checks++;
        if (currPC_out !== 64'd0 || opcode !== 11'd0) begin
            errors++; $display("FAIL reset_regs pc=%h op=%h exp 0/0", currPC_out, opcode);
        end
        @(negedge clk);
        rst = 1'b1; IF_ID_flush = 1'b0;
    endtask

    task automatic test_addi;
        load(32'h91000C22, 64'h10, 1'b0);
        checks++;
        if (w_ctrl !== 15'b000110100001000 || ALU_cntrl !== 3'b010) begin
            errors++; $display("FAIL addi_ctrl got %b/%b exp 000110100001000/010", w_ctrl, ALU_cntrl);
        end
        checks++;
        if (ALU_Imm !== 12'd3 || Rn !== 5'd1 || Rd !== 5'd2 || currPC_out !== 64'h10) begin
            errors++; $display("FAIL addi_fields imm=%0d rn=%0d rd=%0d pc=%h exp 3/1/2/10",
                               ALU_Imm, Rn, Rd, currPC_out);
        end
    endtask

    task automatic test_stur_neg;
        load(32'hF81F8022, 64'h14, 1'b0);
        checks++;
        if (w_ctrl !== 15'b000100001001000 || ALU_cntrl !== 3'b011) begin
            errors++; $display("FAIL stur_neg got %b/%b exp 000100001001000/011", w_ctrl, ALU_cntrl);
        end
        checks++;
        if (dAddr9 !== 9'h1F8 || Rm !== 5'h1F) begin
            errors++; $display("FAIL stur_fields d9=%h rm=%h exp 1f8/1f", dAddr9, Rm);
        end
    endtask

    task automatic test_bl;
        load(32'h94000005, 64'h40, 1'b0);
        checks++;
        if (w_ctrl !== 15'b110010000000001 || ALU_cntrl !== 3'b000) begin
            errors++; $display("FAIL bl_ctrl got %b/%b exp 110010000000001/000", w_ctrl, ALU_cntrl);
        end
        checks++;
        if (brAddr26 !== 26'd5 || currPC_out !== 64'h40) begin
            errors++; $display("FAIL bl_fields br=%h pc=%h exp 5/40", brAddr26, currPC_out);
        end
    endtask

    task automatic test_flush;
        load(32'hEB020023, 64'h44, 1'b0);
        checks++;
        if (w_ctrl !== 15'b001010000001100 || ALU_cntrl !== 3'b011) begin
            errors++; $display("FAIL subs_pre got %b/%b exp 001010000001100/011", w_ctrl, ALU_cntrl);
        end
        load(32'hEB020023, 64'h48, 1'b1);
        checks++;
        if (w_ctrl !== 15'd0 || ALU_cntrl !== 3'd0 || currPC_out !== 64'd0 || opcode !== 11'd0
            || Rd !== 5'd0 || Rm !== 5'd0) begin
            errors++; $display("FAIL flush got ctrl=%b alu=%b pc=%h op=%h exp all 0",
                               w_ctrl, ALU_cntrl, currPC_out, opcode);
        end
        @(negedge clk);
        IF_ID_flush = 1'b0;
    endtask

    task automatic test_async_reset;
        load(32'hF8408022, 64'h50, 1'b0);
        checks++;
        if (w_ctrl !== 15'b000110010101000 || ALU_cntrl !== 3'b010) begin
            errors++; $display("FAIL ldur_pre got %b/%b exp 000110010101000/010", w_ctrl, ALU_cntrl);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (w_ctrl !== 15'd0 || ALU_cntrl !== 3'd0 || currPC_out !== 64'd0 || opcode !== 11'd0) begin
            errors++; $display("FAIL async_rst got ctrl=%b alu=%b pc=%h op=%h exp all 0",
                               w_ctrl, ALU_cntrl, currPC_out, opcode);
        end
        @(negedge clk);
        rst = 1'b1;
        load(32'hD3400841, 64'h58, 1'b0);
        checks++;
        if (w_ctrl !== 15'b000011000010000 || ALU_cntrl !== 3'b000 || shamt !== 6'd2) begin
            errors++; $display("FAIL lsr_after_rst got %b/%b sh=%0d exp 000011000010000/000/2",
                               w_ctrl, ALU_cntrl, shamt);
        end
    endtask

    // Back-to-back sweep over every opcode plus bubbles and the offset-sign rule
    task automatic test_sweep;
        logic [31:0] ins [16];
        logic [14:0] exp_c [16];
        logic [2:0]  exp_a [16];
        ins[0]  = 32'h91000C22; exp_c[0]  = 15'b000110100001000; exp_a[0]  = 3'b010; // ADDI
        ins[1]  = 32'hAB020020; exp_c[1]  = 15'b001010000001100; exp_a[1]  = 3'b010; // ADDS
        ins[2]  = 32'hEB020023; exp_c[2]  = 15'b001010000001100; exp_a[2]  = 3'b011; // SUBS
        ins[3]  = 32'hD3600C41; exp_c[3]  = 15'b000011000000000; exp_a[3]  = 3'b000; // LSL
        ins[4]  = 32'hD3400841; exp_c[4]  = 15'b000011000010000; exp_a[4]  = 3'b000; // LSR
        ins[5]  = 32'hF8408022; exp_c[5]  = 15'b000110010101000; exp_a[5]  = 3'b010; // LDUR +8
        ins[6]  = 32'hF85F8022; exp_c[6]  = 15'b000110010101000; exp_a[6]  = 3'b011; // LDUR -8
        ins[7]  = 32'hF8008022; exp_c[7]  = 15'b000100001001000; exp_a[7]  = 3'b010; // STUR +8
        ins[8]  = 32'h14000003; exp_c[8]  = 15'b110000000000000; exp_a[8]  = 3'b000; // B
        ins[9]  = 32'h94000005; exp_c[9]  = 15'b110010000000001; exp_a[9]  = 3'b000; // BL
        ins[10] = 32'hB4000041; exp_c[10] = 15'b010000000001000; exp_a[10] = 3'b000; // CBZ
        ins[11] = 32'h54000040; exp_c[11] = 15'b010000000000000; exp_a[11] = 3'b000; // B.cond
        ins[12] = 32'hD61F03C0; exp_c[12] = 15'b010000000000010; exp_a[12] = 3'b000; // BR
        ins[13] = 32'h00000000; exp_c[13] = 15'd0;               exp_a[13] = 3'b000; // bubble
        ins[14] = 32'hFFFFFFFF; exp_c[14] = 15'd0;               exp_a[14] = 3'b000; // undefined
        ins[15] = 32'hD61FF000; exp_c[15] = 15'b010000000000010; exp_a[15] = 3'b000; // BR, d9[8]=1
        for (int i = 0; i < 16; i++) begin
            load(ins[i], 64'(32'h100 + 4 * i), 1'b0);
            checks++;
            if (w_ctrl !== exp_c[i] || ALU_cntrl !== exp_a[i]
                || currPC_out !== 64'(32'h100 + 4 * i)) begin
                errors++;
                $display("FAIL sweep_%0d instr=%h got %b/%b pc=%h exp %b/%b pc=%h", i, ins[i],
                         w_ctrl, ALU_cntrl, currPC_out, exp_c[i], exp_a[i], 64'(32'h100 + 4 * i));
            end
        end
    endtask

    initial begin
        rst = 1'b0; IF_ID_flush = 1'b0; instruction = '0; currPC = '0;
        test_reset();
        test_addi();
        test_stur_neg();
        test_bl();
        test_flush();
        test_async_reset();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_decode_ctrl.md
ID_DECODE_CTRL -- requirements
Module: id_decode_ctrl

Interface
REQ-001 Parameter: PC_W, 64, program-counter width.
REQ-002 Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- IF_ID_flush  in  1  synchronous flush of the pipeline register.
- instruction  in  32  fetched instruction.
- currPC  in  PC_W  PC of the fetched instruction.
- currPC_out  out  PC_W  registered PC.
- opcode  out  11  instr[31:21].
- Rn  out  5  instr[9:5].
- Rm  out  5  instr[20:16].
- Rd  out  5  instr[4:0].
- shamt  out  6  instr[15:10].
- dAddr9  out  9  instr[20:12].
- ALU_Imm  out  12  instr[21:10].
- condAddr19  out  19  instr[23:5].
- brAddr26  out  26  instr[25:0].
- uncondBr, branch, Reg2Loc, ALU_Src, RegWrite, ALU_SH, Imm, memToReg, memWrite, memRead, shiftDirn, ALU_on, set_flags, branchReg, branchLink  out  1 each  control signals.
- ALU_cntrl  out  3  ALU operation.

Function
REQ-003 The IF/ID register SHALL capture instruction and currPC on every rising clk edge; there is no stall or enable input.
REQ-004 When IF_ID_flush=1 at an edge, the register SHALL load instruction=0 and PC=0.
REQ-005 All field outputs SHALL be combinational slices of the registered instruction, as listed in REQ-002.
REQ-006 Controls and ALU_cntrl SHALL be purely combinational from the registered opcode and dAddr9[8], with no extra latency: instruction at edge N, controls valid after edge N.
REQ-007 Decode is by opcode prefix. Prefixes:
- ADDI = 1001000100
- ADDS = 10101011000
- SUBS = 11101011000
- LSL = 11010011011
- LSR = 11010011010
- LDUR = 11111000010
- STUR = 11111000000
- B = 000101
- BL = 100101
- CBZ = 10110100
- B.cond = 01010100
- BR = 11010110000
REQ-008 Each instruction SHALL assert only the signals listed; every other control output SHALL be 0.
- ADDI: RegWrite, ALU_Src, Imm, ALU_on; ALU_cntrl=010 (add).
- ADDS: RegWrite, Reg2Loc, ALU_on, set_flags; ALU_cntrl=010.
- SUBS: RegWrite, Reg2Loc, ALU_on, set_flags; ALU_cntrl=011 (sub).
- LSL: RegWrite, ALU_SH; shiftDirn=0 (left).
- LSR: RegWrite, ALU_SH, shiftDirn=1 (right).
- LDUR: RegWrite, ALU_Src, ALU_on, memToReg, memRead; ALU_cntrl=010, or 011 if dAddr9[8]=1.
- STUR: ALU_Src, ALU_on, memWrite; ALU_cntrl per the LDUR rule.
- B: branch, uncondBr.
- BL: branch, uncondBr, branchLink, RegWrite.
- CBZ: branch, ALU_on; ALU_cntrl=000 (pass B).
- B.cond: branch.
- BR: branch, branchReg.
REQ-009 When ALU_on=0, ALU_cntrl SHALL be 000.
REQ-010 An unmatched opcode, including all-zero, SHALL drive all controls 0 (bubble); all-zero never has side effects.
REQ-011 The negative-offset sub rule SHALL apply only to LDUR/STUR.

Reset
REQ-012 While rst=0, the register SHALL asynchronously clear (instruction=0, currPC_out=0), and all control outputs and ALU_cntrl SHALL be forced to 0 regardless of opcode.
REQ-013 After rst returns to 1, the first rising edge SHALL load normally; flush during reset has no additional effect.

Verification
REQ-014 Load 0x91000C22 (ADDI X2,X1,#3) -> after edge: RegWrite=ALU_Src=Imm=ALU_on=1, ALU_cntrl=010, ALU_Imm=3, Rn=1, Rd=2, others 0.
REQ-015 Load STUR with dAddr9=0x1F8 (-8) -> memWrite=ALU_Src=ALU_on=1, ALU_cntrl=011, RegWrite=0, Reg2Loc=0.
REQ-016 Load BL (0x94000005) with currPC=0x40 -> branch=uncondBr=branchLink=RegWrite=1, brAddr26=5, currPC_out=0x40.
REQ-017 Load SUBS, assert IF_ID_flush at next edge -> all outputs 0, currPC_out=0.
REQ-018 Mid-stream rst low between edges -> outputs 0 immediately without a clock edge; release, then load LSR -> RegWrite=ALU_SH=shiftDirn=1.
REQ-019 Sweep all 12 opcodes plus 0x00000000 and an undefined opcode -> control vectors match REQ-008/010 exactly.
